alsu_arbiter: RTL
=================

Name: alsu_arbiter

Overview:
- Shares one 2-cycle-latency ALSU instance between two requesters.
- Accepts packed commands over per-requester valid/ready and grants round-robin.
- Issues one command at a time to the ALSU, waits out the pipeline latency, and returns the 6-bit result with requester id and an invalid-op flag.
- Sits between the command sources and the ALSU input/output pins.

Parameters:
- ALSU_LATENCY, 2, cycles from ALSU input sample edge to out valid; legal 1..7.
- FIRST_PRIORITY, 0, requester favoured on the first arbitration after reset (0 or 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  2  command valid, bit i = requester i
- req_ready  out  2  one-hot accept pulse
- req_cmd_0  in  16  requester 0 command
- req_cmd_1  in  16  requester 1 command
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  1  requester that issued the command
- rsp_data  out  6  captured ALSU out
- rsp_err  out  1  command was an invalid ALSU op
- busy  out  1  high in any state other than IDLE
- alsu_A, alsu_B  out  3 each  ALSU operands
- alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction  out  1 each  ALSU controls
- alsu_opcode  out  3  ALSU opcode
- alsu_out  in  6  ALSU result

Behaviour:
- Command packing, MSB to LSB: [15:13] A, [12:10] B, [9] cin, [8] serial_in, [7] red_op_A, [6] red_op_B, [5:3] opcode, [2] bypass_A, [1] bypass_B, [0] direction.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant one requester. If both are valid, grant the one not granted last. After reset, grant FIRST_PRIORITY.
  - req_ready[g] is combinational: set in IDLE when req_valid[g] is high and g is the grant winner.
  - On the handshake edge, latch the command, latch rsp_id <= g, update the last-grant pointer, and go to ISSUE.
- ISSUE, exactly 1 cycle: drive alsu_* from the latched command. In every other state, drive all alsu_* to 0 (the idle command: OR of zeros, no bypass).
- WAIT: lasts ALSU_LATENCY cycles, counted by a 3-bit counter. On the last WAIT edge, rsp_data <= alsu_out, then go to RESP.
  - With the default latency, one command occupies the ALSU in cycle k; rsp_valid rises in cycle k+3.
- RESP:
  - rsp_valid high; rsp_data, rsp_id and rsp_err stable.
  - Go to IDLE on the edge where rsp_ready is high.
  - No new grant is made until IDLE; req_ready is 0 in ISSUE, WAIT and RESP.
- rsp_err is decoded from the latched command at accept time: (opcode[2]&opcode[1]) | ((red_op_A|red_op_B)&(opcode[2]|opcode[1])).
- Shift and rotate (opcodes 4 and 5) operate on the ALSU's prior out. Because the idle command precedes every issue, that prior out is always 0: shift-left result = {5'b0, serial_in}, shift-right = {serial_in, 5'b0}, rotate = 0.
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, busy 0, all alsu_* 0, last-grant pointer = ~FIRST_PRIORITY.
- Reset mid-operation aborts the in-flight command with no response. The arbiter does not drive the ALSU rst; the idle command flushes ALSU state within ALSU_LATENCY cycles.
- Back-to-back requests from one requester: a lone valid requester is re-granted. Fairness applies only when both are valid.
- rsp_ready held high: RESP lasts exactly 1 cycle, and the next grant occurs in the following IDLE cycle.

Optional Feature:
- Macro: ALSU_ARB_ERR_BLOCK_EN.
- Defined: a command with rsp_err=1 is never driven to the ALSU. The FSM goes directly from IDLE to RESP with rsp_data=0, rsp_err=1, so rsp_valid rises in cycle k+1.
- Undefined: invalid commands are issued normally; rsp_data = captured alsu_out and rsp_err=1.

Test Plan:
- Req0 only, A=3, B=2, cin=1, opcode=2 -> req_ready[0] pulse; rsp_valid 3 cycles later; rsp_data=6, rsp_id=0, rsp_err=0.
- Both valid every cycle, 4 commands each, opcode=3, A=i, B=2 -> grants alternate 0,1,0,1… after FIRST_PRIORITY; rsp_data=2*A; no requester starved.
- Req1 opcode=4, direction=1, serial_in=1, A=5 -> rsp_data=6'b000001, rsp_id=1.
- Req0 opcode=6, A=7, B=7 -> rsp_err=1. With ALSU_ARB_ERR_BLOCK_EN: rsp_data=0, rsp_valid 1 cycle after accept, alsu_opcode stays 0. Without it: alsu_opcode=6 for one cycle.
- rsp_ready held low 5 cycles with req1 pending -> rsp fields stable, req_ready=0; grant to 1 in the cycle after the rsp_ready handshake.
- rst asserted in WAIT -> next cycle: state IDLE, rsp_valid=0, busy=0, no response ever produced for the aborted command.

Source files
------------

// File: rtl/alsu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ALSU between two requesters.
// Optional: define ALSU_ARB_ERR_BLOCK_EN to answer invalid ops without issuing them.
module alsu_arbiter #(
  parameter int ALSU_LATENCY   = 2,
  parameter int FIRST_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_cmd_0,
  input  logic [15:0] req_cmd_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [5:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [2:0]  alsu_A,
  output logic [2:0]  alsu_B,
  output logic        alsu_cin,
  output logic        alsu_serial_in,
  output logic        alsu_red_op_A,
  output logic        alsu_red_op_B,
  output logic        alsu_bypass_A,
  output logic        alsu_bypass_B,
  output logic        alsu_direction,
  output logic [2:0]  alsu_opcode,
  input  logic [5:0]  alsu_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] LAST_WAIT  = 3'(ALSU_LATENCY - 1);
  localparam logic       RESET_LAST = (FIRST_PRIORITY == 0);
`ifdef ALSU_ARB_ERR_BLOCK_EN
  localparam logic BLOCK_ERR = 1'b1;
`else
  localparam logic BLOCK_ERR = 1'b0;
`endif

  state_t      state, next_state;
  logic        last_grant;
  logic        grant;
  logic        accept;
  logic        sel_err;
  logic        wait_done;
  logic [15:0] sel_cmd;
  logic [15:0] cmd;
  logic [2:0]  wait_cnt;

  function automatic logic cmd_err(input logic [15:0] c);
    return (c[5] & c[4]) | ((c[7] | c[6]) & (c[5] | c[4]));
  endfunction

  // A lone requester always wins; contention goes to whoever was not served last.
  assign grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
  assign sel_cmd   = grant ? req_cmd_1 : req_cmd_0;
  assign sel_err   = cmd_err(sel_cmd);
  assign accept    = (state == IDLE) && (req_valid != 2'b00);
  assign wait_done = (state == WAIT) && (wait_cnt == LAST_WAIT);

  always_comb begin
    next_state     = state;
    req_ready      = 2'b00;
    rsp_valid      = 1'b0;
    busy           = (state != IDLE);
    alsu_A         = 3'd0;
    alsu_B         = 3'd0;
    alsu_cin       = 1'b0;
    alsu_serial_in = 1'b0;
    alsu_red_op_A  = 1'b0;
    alsu_red_op_B  = 1'b0;
    alsu_opcode    = 3'd0;
    alsu_bypass_A  = 1'b0;
    alsu_bypass_B  = 1'b0;
    alsu_direction = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready  = grant ? 2'b10 : 2'b01;
          next_state = (BLOCK_ERR && sel_err) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        alsu_A         = cmd[15:13];
        alsu_B         = cmd[12:10];
        alsu_cin       = cmd[9];
        alsu_serial_in = cmd[8];
        alsu_red_op_A  = cmd[7];
        alsu_red_op_B  = cmd[6];
        alsu_opcode    = cmd[5:3];
        alsu_bypass_A  = cmd[2];
        alsu_bypass_B  = cmd[1];
        alsu_direction = cmd[0];
        next_state     = WAIT;
      end
      WAIT: begin
        if (wait_done) next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= RESET_LAST;
      cmd        <= '0;
      wait_cnt   <= '0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        cmd        <= sel_cmd;
        rsp_id     <= grant;
        rsp_err    <= sel_err;
        last_grant <= grant;
        rsp_data   <= '0;
      end
      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 3'd1;
      if (wait_done) rsp_data <= alsu_out;
    end
  end

endmodule
